// File: rtl/mm_arbiter_pkg.sv
// Shared constants, state type and width helper for the MemoryMapped N:1 arbiter.
package mm_arbiter_pkg;

    localparam int SCHEME_RR    = 0;
    localparam int SCHEME_FIXED = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Keeps index and counter vectors at least one bit wide for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_arb_select.sv
// Combinational winner pick: round-robin from a start pointer, or lowest index first.
module mm_arb_select
    import mm_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         scheme,
    output logic [W-1:0] idx,
    output logic         any_req
);

    logic [W-1:0] cand;

    // Scan from the far end so the last hit is the nearest candidate in search order.
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = (scheme == 1'(SCHEME_RR)) ? W'((int'(ptr) + i) % N) : W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mm_arbiter.sv
// N-master to 1-slave MemoryMapped arbiter with selectable scheme and per-transaction timeout.
//   state | meaning
//   IDLE  | no owner; pick a winner among requesters (one cycle of arbitration)
//   BUSY  | granted channel mirrored to the slave until completion, abort or timeout
module mm_arbiter
    import mm_arbiter_pkg::*;
#(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int MCOUNT  = 4,
    parameter int SCHEME  = 0,
    parameter int TIMEOUT = 256
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [MCOUNT*AWIDTH-1:0]           s_addr,
    input  logic [MCOUNT-1:0]                  s_wreq,
    input  logic [MCOUNT*DWIDTH-1:0]           s_wdat,
    input  logic [MCOUNT-1:0]                  s_rreq,
    output logic [MCOUNT*DWIDTH-1:0]           s_rdat,
    output logic [MCOUNT-1:0]                  s_rdyn,
    output logic [AWIDTH-1:0]                  m_addr,
    output logic                               m_wreq,
    output logic [DWIDTH-1:0]                  m_wdat,
    output logic                               m_rreq,
    input  logic [DWIDTH-1:0]                  m_rdat,
    input  logic                               m_rdyn,
    output logic [clog2_min1(MCOUNT)-1:0]      grant,
    output logic                               tout
);

    localparam int GW = clog2_min1(MCOUNT);
    localparam int CW = clog2_min1(TIMEOUT);
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t     state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  ptr_q, ptr_d;
    logic [GW-1:0]  ptr_adv;
    logic [GW-1:0]  win;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [MCOUNT-1:0] req;
    logic           any_req;
    logic           g_req;
    logic           limit;

    assign req     = s_wreq | s_rreq;
    assign g_req   = req[grant_q];
    assign limit   = (TIMEOUT > 0) && (cnt_q == TLIM);
    assign ptr_adv = (grant_q == GW'(MCOUNT - 1)) ? '0 : grant_q + GW'(1);
    assign grant   = grant_q;

    mm_arb_select #(
        .N (MCOUNT),
        .W (GW)
    ) u_select (
        .req     (req),
        .ptr     (ptr_q),
        .scheme  ((SCHEME == SCHEME_FIXED) ? 1'b1 : 1'b0),
        .idx     (win),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        m_addr  = '0;
        m_wdat  = '0;
        m_wreq  = 1'b0;
        m_rreq  = 1'b0;
        s_rdyn  = '1;
        s_rdat  = {MCOUNT{m_rdat}};
        tout    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    grant_d = win;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                m_addr          = s_addr[grant_q*AWIDTH +: AWIDTH];
                m_wdat          = s_wdat[grant_q*DWIDTH +: DWIDTH];
                m_wreq          = s_wreq[grant_q];
                m_rreq          = s_rreq[grant_q];
                s_rdyn[grant_q] = m_rdyn;
                // A master that withdraws mid-transaction does not earn a pointer advance.
                if (!g_req) begin
                    state_d = IDLE;
                end else if (!m_rdyn) begin
                    state_d = IDLE;
                    ptr_d   = ptr_adv;
                end else if (limit) begin
                    m_wreq                             = 1'b0;
                    m_rreq                             = 1'b0;
                    s_rdyn[grant_q]                    = 1'b0;
                    s_rdat[grant_q*DWIDTH +: DWIDTH]   = '1;
                    tout                               = 1'b1;
                    state_d                            = IDLE;
                    ptr_d                              = ptr_adv;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mm_arbiter.sv
// Bench for mm_arbiter: a round-robin and a fixed-priority instance against a cycle-level reference model.
module tb_mm_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 8;
    localparam int NI = 2;

    logic            clk;
    logic            reset;
    logic [N*AW-1:0] s_addr [NI];
    logic [N-1:0]    s_wreq [NI];
    logic [N*DW-1:0] s_wdat [NI];
    logic [N-1:0]    s_rreq [NI];
    logic [N*DW-1:0] s_rdat [NI];
    logic [N-1:0]    s_rdyn [NI];
    logic [AW-1:0]   m_addr [NI];
    logic            m_wreq [NI];
    logic [DW-1:0]   m_wdat [NI];
    logic            m_rreq [NI];
    logic [DW-1:0]   m_rdat [NI];
    logic            m_rdyn [NI];
    logic [1:0]      grant  [NI];
    logic            tout   [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: owner = -1 when nobody holds the bus; waited = BUSY cycles so far incl. current.
    int owner  [NI];
    int waited [NI];
    int ptr    [NI];
    int gnt    [NI];
    int nx_owner  [NI];
    int nx_waited [NI];
    int nx_ptr    [NI];
    int nx_gnt    [NI];
    bit [N-1:0] done [NI];
    bit [N-1:0] act  [NI];

    int         rr_order [5];
    logic [N-1:0] er;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        mm_arbiter #(
            .AWIDTH  (AW),
            .DWIDTH  (DW),
            .MCOUNT  (N),
            .SCHEME  (k),
            .TIMEOUT (TO)
        ) dut (
            .clk    (clk),
            .reset  (reset),
            .s_addr (s_addr[k]),
            .s_wreq (s_wreq[k]),
            .s_wdat (s_wdat[k]),
            .s_rreq (s_rreq[k]),
            .s_rdat (s_rdat[k]),
            .s_rdyn (s_rdyn[k]),
            .m_addr (m_addr[k]),
            .m_wreq (m_wreq[k]),
            .m_wdat (m_wdat[k]),
            .m_rreq (m_rreq[k]),
            .m_rdat (m_rdat[k]),
            .m_rdyn (m_rdyn[k]),
            .grant  (grant[k]),
            .tout   (tout[k])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            owner[k]  = -1;
            waited[k] = 0;
            ptr[k]    = 0;
            gnt[k]    = 0;
            done[k]   = '0;
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < NI; k++) begin
            s_addr[k] = '0;
            s_wdat[k] = '0;
            s_wreq[k] = '0;
            s_rreq[k] = '0;
            m_rdat[k] = '0;
            m_rdyn[k] = 1'b1;
            act[k]    = '0;
        end
    endtask

    // Instance 1 is fixed priority (lowest index); instance 0 searches upward from its pointer.
    function automatic int pick(input int k, input logic [N-1:0] rq);
        int c;
        for (int off = 0; off < N; off++) begin
            c = (k == 1) ? off : (ptr[k] + off) % N;
            if (rq[c]) return c;
        end
        return -1;
    endfunction

    task automatic eval();
        #1;
        for (int k = 0; k < NI; k++) begin
            logic [N-1:0]    rq;
            logic [N*DW-1:0] e_rdat;
            logic [N-1:0]    e_rdyn;
            logic [AW-1:0]   e_addr;
            logic [DW-1:0]   e_wdat;
            logic            e_wreq;
            logic            e_rreq;
            logic            e_tout;
            int              g;
            rq        = s_wreq[k] | s_rreq[k];
            e_rdat    = {N{m_rdat[k]}};
            e_rdyn    = '1;
            e_addr    = '0;
            e_wdat    = '0;
            e_wreq    = 1'b0;
            e_rreq    = 1'b0;
            e_tout    = 1'b0;
            nx_owner[k]  = owner[k];
            nx_waited[k] = waited[k];
            nx_ptr[k]    = ptr[k];
            nx_gnt[k]    = gnt[k];
            done[k]      = '0;
            g = owner[k];
            if (g < 0) begin
                if (rq != '0) begin
                    nx_owner[k]  = pick(k, rq);
                    nx_gnt[k]    = nx_owner[k];
                    nx_waited[k] = 1;
                end
            end else begin
                e_addr    = s_addr[k][g*AW +: AW];
                e_wdat    = s_wdat[k][g*DW +: DW];
                e_wreq    = s_wreq[k][g];
                e_rreq    = s_rreq[k][g];
                e_rdyn[g] = m_rdyn[k];
                if (!rq[g]) begin
                    nx_owner[k] = -1;
                end else if (!m_rdyn[k] || waited[k] == TO) begin
                    if (m_rdyn[k]) begin
                        e_wreq              = 1'b0;
                        e_rreq              = 1'b0;
                        e_rdyn[g]           = 1'b0;
                        e_rdat[g*DW +: DW]  = '1;
                        e_tout              = 1'b1;
                    end
                    nx_owner[k] = -1;
                    nx_ptr[k]   = (g + 1) % N;
                    done[k][g]  = 1'b1;
                end else begin
                    nx_waited[k] = waited[k] + 1;
                end
            end
            chk($sformatf("i%0d grant", k),  64'(grant[k]),  64'(gnt[k]));
            chk($sformatf("i%0d m_wreq", k), 64'(m_wreq[k]), 64'(e_wreq));
            chk($sformatf("i%0d m_rreq", k), 64'(m_rreq[k]), 64'(e_rreq));
            chk($sformatf("i%0d m_addr", k), 64'(m_addr[k]), 64'(e_addr));
            chk($sformatf("i%0d m_wdat", k), 64'(m_wdat[k]), 64'(e_wdat));
            chk($sformatf("i%0d s_rdyn", k), 64'(s_rdyn[k]), 64'(e_rdyn));
            chk($sformatf("i%0d s_rdat", k), 64'(s_rdat[k]), 64'(e_rdat));
            chk($sformatf("i%0d tout", k),   64'(tout[k]),   64'(e_tout));
        end
    endtask

    task automatic tick();
        for (int k = 0; k < NI; k++) begin
            owner[k]  = nx_owner[k];
            waited[k] = nx_waited[k];
            ptr[k]    = nx_ptr[k];
            gnt[k]    = nx_gnt[k];
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_random();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < N; i++) begin
                if (done[k][i]) begin
                    act[k][i]    = 1'b0;
                    s_wreq[k][i] = 1'b0;
                    s_rreq[k][i] = 1'b0;
                end
                if (!act[k][i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        act[k][i]              = 1'b1;
                        s_wreq[k][i]           = 1'($urandom_range(0, 1));
                        s_rreq[k][i]           = ~s_wreq[k][i];
                        s_addr[k][i*AW +: AW]  = AW'($urandom);
                        s_wdat[k][i*DW +: DW]  = DW'($urandom);
                    end
                end else if ($urandom_range(0, 199) == 0) begin
                    act[k][i]    = 1'b0;
                    s_wreq[k][i] = 1'b0;
                    s_rreq[k][i] = 1'b0;
                end
            end
            m_rdyn[k] = ($urandom_range(0, 3) != 0);
            m_rdat[k] = DW'($urandom);
        end
    endtask

    initial begin
        rr_order = '{0, 1, 2, 3, 0};
        model_reset();
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        for (int k = 0; k < NI; k++) begin
            chk("rst grant",  64'(grant[k]),  64'h0);
            chk("rst m_wreq", 64'(m_wreq[k]), 64'h0);
            chk("rst m_rreq", 64'(m_rreq[k]), 64'h0);
            chk("rst m_addr", 64'(m_addr[k]), 64'h0);
            chk("rst m_wdat", 64'(m_wdat[k]), 64'h0);
            chk("rst s_rdyn", 64'(s_rdyn[k]), 64'hF);
            chk("rst tout",   64'(tout[k]),   64'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin, all four channels reading back to back.
        s_rreq[0] = 4'hF;
        m_rdyn[0] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            m_rdat[0] = DW'($urandom);
            eval();
            if (t % 2 == 1) begin
                er = '1;
                er[rr_order[t/2]] = 1'b0;
                chk("rr order", 64'(grant[0]), 64'(rr_order[t/2]));
                chk("rr rdyn",  64'(s_rdyn[0]), 64'(er));
                for (int i = 0; i < N; i++) begin
                    chk("rr rdat", 64'(s_rdat[0][i*DW +: DW]), 64'(m_rdat[0]));
                end
            end
            tick();
        end
        s_rreq[0] = '0;

        // Single write from channel 2.
        s_wreq[0][2]           = 1'b1;
        s_addr[0][2*AW +: AW]  = 8'h15;
        s_wdat[0][2*DW +: DW]  = 8'hA5;
        m_rdyn[0]              = 1'b0;
        eval();
        chk("wr latency", 64'(m_wreq[0]), 64'h0);
        tick();
        eval();
        chk("wr m_wreq", 64'(m_wreq[0]), 64'h1);
        chk("wr m_addr", 64'(m_addr[0]), 64'h15);
        chk("wr m_wdat", 64'(m_wdat[0]), 64'hA5);
        chk("wr s_rdyn2", 64'(s_rdyn[0][2]), 64'h0);
        chk("wr grant", 64'(grant[0]), 64'h2);
        tick();
        s_wreq[0] = '0;
        eval();
        tick();

        // Fixed priority: channel 1 beats channel 3 twice in a row.
        s_rreq[1] = 4'b1010;
        m_rdyn[1] = 1'b0;
        for (int t = 0; t < 6; t++) begin
            if (t == 4) s_rreq[1][1] = 1'b0;
            eval();
            if (t == 1 || t == 3) begin
                chk("fx first", 64'(grant[1]), 64'h1);
                chk("fx wait3", 64'(s_rdyn[1][3]), 64'h1);
            end
            if (t == 5) chk("fx later", 64'(grant[1]), 64'h3);
            tick();
        end
        s_rreq[1] = '0;
        eval();
        tick();

        // Timeout on a stalled read.
        s_rreq[0][0] = 1'b1;
        m_rdyn[0]    = 1'b1;
        for (int t = 0; t <= 8; t++) begin
            m_rdat[0] = DW'($urandom_range(0, 254));
            eval();
            if (t >= 1 && t <= 7) begin
                chk("to early tout", 64'(tout[0]), 64'h0);
                chk("to early rreq", 64'(m_rreq[0]), 64'h1);
            end
            if (t == 8) begin
                chk("to tout",   64'(tout[0]), 64'h1);
                chk("to rdyn0",  64'(s_rdyn[0][0]), 64'h0);
                chk("to rdat0",  64'(s_rdat[0][7:0]), 64'hFF);
                chk("to rdat1",  64'(s_rdat[0][15:8]), 64'(m_rdat[0]));
                chk("to rreq",   64'(m_rreq[0]), 64'h0);
            end
            tick();
        end
        s_rreq[0] = '0;
        eval();
        chk("to idle", 64'(tout[0]), 64'h0);
        tick();

        // Completion on the limit cycle beats the timeout.
        s_rreq[0][0] = 1'b1;
        for (int t = 0; t <= 8; t++) begin
            m_rdyn[0] = (t != 8);
            m_rdat[0] = DW'($urandom_range(0, 254));
            eval();
            if (t == 8) begin
                chk("race tout",  64'(tout[0]), 64'h0);
                chk("race rdat0", 64'(s_rdat[0][7:0]), 64'(m_rdat[0]));
                chk("race rdyn0", 64'(s_rdyn[0][0]), 64'h0);
                chk("race rreq",  64'(m_rreq[0]), 64'h1);
            end
            tick();
        end
        s_rreq[0] = '0;
        m_rdyn[0] = 1'b1;
        eval();
        tick();

        // Reset in the middle of a stalled transaction; pointer was 3 beforehand.
        s_rreq[0][2] = 1'b1;
        m_rdyn[0]    = 1'b0;
        eval();
        tick();
        eval();
        tick();
        s_rreq[0] = 4'b1000;
        m_rdyn[0] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            eval();
            tick();
        end
        reset = 1'b0;
        #1;
        chk("midrst m_wreq", 64'(m_wreq[0]), 64'h0);
        chk("midrst m_rreq", 64'(m_rreq[0]), 64'h0);
        chk("midrst tout",   64'(tout[0]),   64'h0);
        chk("midrst s_rdyn", 64'(s_rdyn[0]), 64'hF);
        chk("midrst grant",  64'(grant[0]),  64'h0);
        model_reset();
        @(posedge clk);
        #1;
        s_rreq[0] = 4'b1010;
        m_rdyn[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        eval();
        tick();
        eval();
        chk("postrst grant", 64'(grant[0]), 64'h1);
        tick();
        s_rreq[0] = '0;
        eval();
        tick();

        // Random traffic on both instances.
        clear_inputs();
        for (int k = 0; k < NI; k++) done[k] = '0;
        repeat (1500) begin
            drive_random();
            eval();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
